// File: rtl/dev_trace_pkg.sv
// Shared record layout and helpers for the device register trace block.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package dev_trace_pkg;

    // 56-bit record, MSB first: stamp, src, type, hi, lo, reg, data.
    // The source field keeps only the two low bits of the device index.
    localparam int REC_W     = 56;
    localparam int STAMP_MSB = 55;
    localparam int STAMP_LSB = 24;
    localparam int SRC_MSB   = 23;
    localparam int SRC_LSB   = 22;
    localparam int TYPE_BIT  = 21;
    localparam int HI_BIT    = 20;
    localparam int LO_BIT    = 19;
    localparam int REG_MSB   = 18;
    localparam int REG_LSB   = 16;
    localparam int DATA_MSB  = 15;
    localparam int DATA_LSB  = 0;

    localparam logic EV_READ  = 1'b0;
    localparam logic EV_WRITE = 1'b1;

    typedef struct packed {
        logic [31:0] stamp;
        logic [1:0]  src;
        logic        typ;
        logic        hi;
        logic        lo;
        logic [2:0]  rsel;
        logic [15:0] data;
    } trace_rec_t;

    function automatic trace_rec_t make_rec(
        input logic [31:0] stamp,
        input logic [1:0]  src,
        input logic        typ,
        input logic        hi,
        input logic        lo,
        input logic [2:0]  rsel,
        input logic [15:0] data
    );
        trace_rec_t r;
        r.stamp = stamp;
        r.src   = src;
        r.typ   = typ;
        r.hi    = hi;
        r.lo    = lo;
        r.rsel  = rsel;
        r.data  = data;
        return r;
    endfunction

endpackage

// File: rtl/trace_fifo.sv
// Synchronous show-ahead FIFO: head word is presented whenever not empty.
// Latency: a pushed word is visible on pop_dat the cycle after the push edge.
// Backpressure: push ignored while full (even with a same-cycle pop); pop ignored while empty.
// Ports: push/push_dat write side, pop/pop_dat read side, full/empty/count status.
module trace_fifo #(
    parameter int DEPTH = 16,
    parameter int W     = 56
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic [W-1:0]             push_dat,
    input  logic                     pop,
    output logic [W-1:0]             pop_dat,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int AW = $clog2(DEPTH);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wptr;
    logic [AW-1:0] rptr;
    logic          do_push;
    logic          do_pop;

    assign full    = (count == (AW+1)'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;

    // Storage is not reset; the output is forced to zero while empty instead.
    assign pop_dat = empty ? '0 : mem[rptr];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wptr] <= push_dat;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            if (do_push) begin
                wptr <= wptr + 1'b1;
            end
            if (do_pop) begin
                rptr <= rptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/dev_reg_trace_arb.sv
// Captures completed device register reads/writes as timestamped records, round-robin into a FIFO.
// Latency: strobe fall sampled at edge k loads pending; edge k+1 pushes; trcVALID high after k+1.
// Backpressure: trcVALID/trcREADY drain; full FIFO stalls grants; a second event on a busy pending slot is dropped and flagged in ovfl.
// Ports: clk/rst_n; trcEN capture enable; dev* strobes, lanes and write data; reg* addressed value/index;
//        trcDATA/trcVALID/trcREADY drain; ovfl/ovflCLR sticky drop flags; fifoCNT occupancy.
module dev_reg_trace_arb
    import dev_trace_pkg::*;
#(
    parameter int NDEV  = 4,
    parameter int DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     trcEN,
    input  logic [NDEV-1:0]          devRD,
    input  logic [NDEV-1:0]          devWR,
    input  logic [NDEV-1:0]          devHIBYTE,
    input  logic [NDEV-1:0]          devLOBYTE,
    input  logic [NDEV*16-1:0]       devDATA,
    input  logic [NDEV*16-1:0]       regVAL,
    input  logic [NDEV*3-1:0]        regSEL,
    output logic [REC_W-1:0]         trcDATA,
    output logic                     trcVALID,
    input  logic                     trcREADY,
    output logic [NDEV-1:0]          ovfl,
    input  logic                     ovflCLR,
    output logic [$clog2(DEPTH):0]   fifoCNT
);
    logic [31:0]     stamp;
    logic [NDEV-1:0] last_rd, last_wr;
    logic [NDEV-1:0] rd_ev, wr_ev, wr_start, ev, drop;
    logic [15:0]     sh_data [NDEV];
    logic [2:0]      sh_reg  [NDEV];
    logic [NDEV-1:0] sh_hi, sh_lo;
    trace_rec_t      new_rec  [NDEV];
    trace_rec_t      pend_rec [NDEV];
    logic [NDEV-1:0] pend_vld;
    logic [NDEV-1:0] gnt;
    logic [2:0]      rr_ptr, gnt_idx, cand;
    logic            gnt_vld;
    logic [7:0]      pend_x;
    trace_rec_t      push_rec;
    logic            fifo_full, fifo_empty;

    assign rd_ev    = last_rd & ~devRD;
    assign wr_ev    = last_wr & ~devWR;
    assign wr_start = ~last_wr & devWR;
    assign ev       = {NDEV{trcEN}} & (rd_ev | wr_ev);
    // A granted slot is freed in the same cycle, so it can accept a new event.
    assign drop     = ev & pend_vld & ~gnt;

    // Reads take live lanes/index/value; writes replay what was latched at write start.
    always_comb begin
        for (int i = 0; i < NDEV; i++) begin
            new_rec[i] = make_rec(stamp, 2'(i),
                                  wr_ev[i] ? EV_WRITE : EV_READ,
                                  wr_ev[i] ? sh_hi[i]   : devHIBYTE[i],
                                  wr_ev[i] ? sh_lo[i]   : devLOBYTE[i],
                                  wr_ev[i] ? sh_reg[i]  : regSEL[3*i +: 3],
                                  wr_ev[i] ? sh_data[i] : regVAL[16*i +: 16]);
        end
    end

    // Round-robin search starting at rr_ptr; nothing is granted while the FIFO is full.
    always_comb begin
        pend_x             = '0;
        pend_x[NDEV-1:0]   = pend_vld;
        gnt_vld            = 1'b0;
        gnt_idx            = '0;
        cand               = '0;
        if (!fifo_full) begin
            for (int k = 0; k < NDEV; k++) begin
                cand = 3'((int'(rr_ptr) + k) % NDEV);
                if (!gnt_vld && pend_x[cand]) begin
                    gnt_vld = 1'b1;
                    gnt_idx = cand;
                end
            end
        end
    end

    always_comb begin
        push_rec = '0;
        for (int i = 0; i < NDEV; i++) begin
            gnt[i] = gnt_vld && (gnt_idx == 3'(i));
            if (gnt[i]) begin
                push_rec = pend_rec[i];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stamp   <= '0;
            last_rd <= '0;
            last_wr <= '0;
        end else begin
            stamp   <= stamp + 32'd1;
            last_rd <= devRD;
            last_wr <= devWR;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend_vld <= '0;
            sh_hi    <= '0;
            sh_lo    <= '0;
            ovfl     <= '0;
            rr_ptr   <= '0;
            for (int i = 0; i < NDEV; i++) begin
                pend_rec[i] <= '0;
                sh_data[i]  <= '0;
                sh_reg[i]   <= '0;
            end
        end else begin
            for (int i = 0; i < NDEV; i++) begin
                // Shadow is captured regardless of trcEN so a write that
                // straddles an enable change still reports its start data.
                if (wr_start[i]) begin
                    sh_data[i] <= devDATA[16*i +: 16];
                    sh_reg[i]  <= regSEL[3*i +: 3];
                    sh_hi[i]   <= devHIBYTE[i];
                    sh_lo[i]   <= devLOBYTE[i];
                end
                if (ev[i] && (!pend_vld[i] || gnt[i])) begin
                    pend_rec[i] <= new_rec[i];
                    pend_vld[i] <= 1'b1;
                end else if (gnt[i]) begin
                    pend_vld[i] <= 1'b0;
                end
            end
            // A drop in the same cycle as a clear keeps its bit set.
            ovfl <= (ovflCLR ? '0 : ovfl) | drop;
            if (gnt_vld) begin
                rr_ptr <= (gnt_idx == 3'(NDEV-1)) ? 3'd0 : gnt_idx + 3'd1;
            end
        end
    end

    trace_fifo #(
        .DEPTH (DEPTH),
        .W     (REC_W)
    ) u_fifo (
        .clk      (clk),
        .rst_n    (rst_n),
        .push     (gnt_vld),
        .push_dat (push_rec),
        .pop      (trcVALID & trcREADY),
        .pop_dat  (trcDATA),
        .full     (fifo_full),
        .empty    (fifo_empty),
        .count    (fifoCNT)
    );

    assign trcVALID = ~fifo_empty;

endmodule

// File: tb/tb_dev_reg_trace_arb.sv
module tb_dev_reg_trace_arb;
    import dev_trace_pkg::*;

    localparam int NDEV  = 4;
    localparam int DEPTH = 16;

    logic        clk = 1'b0;
    logic        rst_n, trcEN, trcREADY, ovflCLR;
    logic [3:0]  devRD, devWR, devHIBYTE, devLOBYTE;
    logic [63:0] devDATA, regVAL;
    logic [11:0] regSEL;
    logic [55:0] trcDATA;
    logic        trcVALID;
    logic [3:0]  ovfl;
    logic [4:0]  fifoCNT;

    int errors = 0;
    int checks = 0;
    bit cmp_en = 1'b0;

    always #5 clk = ~clk;

    dev_reg_trace_arb #(.NDEV(NDEV), .DEPTH(DEPTH)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .trcEN     (trcEN),
        .devRD     (devRD),
        .devWR     (devWR),
        .devHIBYTE (devHIBYTE),
        .devLOBYTE (devLOBYTE),
        .devDATA   (devDATA),
        .regVAL    (regVAL),
        .regSEL    (regSEL),
        .trcDATA   (trcDATA),
        .trcVALID  (trcVALID),
        .trcREADY  (trcREADY),
        .ovfl      (ovfl),
        .ovflCLR   (ovflCLR),
        .fifoCNT   (fifoCNT)
    );

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h t=%0t", nm, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    trace_rec_t  mq[$];
    trace_rec_t  m_pr [NDEV];
    logic [3:0]  m_pv = '0;
    int          m_ptr = 0;
    logic [3:0]  m_ovfl = '0;
    logic [31:0] m_stamp = '0;
    logic [3:0]  m_prd = '0, m_pwr = '0;
    logic [15:0] m_sd [NDEV];
    logic [2:0]  m_sreg [NDEV];
    logic [3:0]  m_shi = '0, m_slo = '0;
    int          ld_seq = 0, ld_seen = 0;
    logic [31:0] ld_val = '0;
    logic [31:0] s;
    int          g, idx;
    logic [3:0]  drops;
    logic        m_full, rdv, wrv;
    trace_rec_t  nr, exp_head;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mq.delete();
            m_pv = '0; m_ptr = 0; m_ovfl = '0; m_stamp = '0;
            m_prd = '0; m_pwr = '0; m_shi = '0; m_slo = '0;
            for (int i = 0; i < NDEV; i++) begin
                m_sd[i] = '0; m_sreg[i] = '0;
            end
            ld_seen = ld_seq;
        end else begin
            s = (ld_seq != ld_seen) ? ld_val : m_stamp;
            ld_seen = ld_seq;
            m_stamp = s + 32'd1;
            m_full = (mq.size() == DEPTH);
            if (mq.size() > 0 && trcREADY) void'(mq.pop_front());
            g = -1;
            if (!m_full) begin
                for (int k = 0; k < NDEV; k++) begin
                    idx = (m_ptr + k) % NDEV;
                    if (g < 0 && m_pv[idx]) g = idx;
                end
            end
            if (g >= 0) begin
                mq.push_back(m_pr[g]);
                m_pv[g] = 1'b0;
                m_ptr = (g + 1) % NDEV;
            end
            drops = '0;
            for (int i = 0; i < NDEV; i++) begin
                rdv = m_prd[i] && !devRD[i];
                wrv = m_pwr[i] && !devWR[i];
                if (trcEN && (rdv || wrv)) begin
                    nr.stamp = s;
                    nr.src   = 2'(i);
                    nr.typ   = wrv;
                    nr.hi    = wrv ? m_shi[i]  : devHIBYTE[i];
                    nr.lo    = wrv ? m_slo[i]  : devLOBYTE[i];
                    nr.rsel  = wrv ? m_sreg[i] : regSEL[3*i +: 3];
                    nr.data  = wrv ? m_sd[i]   : regVAL[16*i +: 16];
                    if (!m_pv[i]) begin
                        m_pr[i] = nr;
                        m_pv[i] = 1'b1;
                    end else begin
                        drops[i] = 1'b1;
                    end
                end
                if (!m_pwr[i] && devWR[i]) begin
                    m_sd[i]   = devDATA[16*i +: 16];
                    m_sreg[i] = regSEL[3*i +: 3];
                    m_shi[i]  = devHIBYTE[i];
                    m_slo[i]  = devLOBYTE[i];
                end
            end
            m_ovfl = (ovflCLR ? 4'b0 : m_ovfl) | drops;
            m_prd = devRD;
            m_pwr = devWR;
        end
    end

    // Every-cycle comparison against the model.
    always @(negedge clk) begin
        if (cmp_en) begin
            exp_head = (mq.size() > 0) ? mq[0] : '0;
            chk("m_valid", 64'(trcVALID), 64'(mq.size() > 0));
            chk("m_data",  64'(trcDATA),  64'(exp_head));
            chk("m_cnt",   64'(fifoCNT),  64'(mq.size()));
            chk("m_ovfl",  64'(ovfl),     64'(m_ovfl));
        end
    end

    // ---------------- stimulus ----------------
    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic drain(input int n);
        trcREADY = 1'b1;
        repeat (n) tick();
        trcREADY = 1'b0;
    endtask

    task automatic rd_pulse(input int d);
        devRD[d] = 1'b1;
        tick();
        devRD[d] = 1'b0;
        tick();
    endtask

    initial begin
        rst_n = 1'b0; trcEN = 1'b1; trcREADY = 1'b0; ovflCLR = 1'b0;
        devRD = '0; devWR = '0; devHIBYTE = '0; devLOBYTE = '0;
        devDATA = '0; regVAL = '0; regSEL = '0;
        tick(); tick();
        cmp_en = 1'b1;
        chk("rst_valid", 64'(trcVALID), 64'd0);
        chk("rst_data",  64'(trcDATA),  64'd0);
        chk("rst_cnt",   64'(fifoCNT),  64'd0);
        chk("rst_ovfl",  64'(ovfl),     64'd0);
        rst_n = 1'b1;
        tick();

        // Single read on device 1
        regSEL[5:3] = 3'd2; regVAL[31:16] = 16'o123456;
        devHIBYTE[1] = 1'b1; devLOBYTE[1] = 1'b0;
        devRD[1] = 1'b1;
        repeat (3) tick();
        devRD[1] = 1'b0;
        tick();
        chk("rd_valid_k", 64'(trcVALID), 64'd0);
        tick();
        chk("rd_valid_k1", 64'(trcVALID), 64'd1);
        chk("rd_src",  64'(trcDATA[SRC_MSB:SRC_LSB]),   64'd1);
        chk("rd_type", 64'(trcDATA[TYPE_BIT]),          64'd0);
        chk("rd_reg",  64'(trcDATA[REG_MSB:REG_LSB]),   64'd2);
        chk("rd_data", 64'(trcDATA[DATA_MSB:DATA_LSB]), 64'o123456);
        chk("rd_hi",   64'(trcDATA[HI_BIT]),            64'd1);
        drain(1);

        // Write on device 0: data and lanes latched at write start
        regSEL[2:0] = 3'd5; devDATA[15:0] = 16'o000377;
        devLOBYTE[0] = 1'b1; devHIBYTE[0] = 1'b0;
        devWR[0] = 1'b1;
        tick();
        devDATA[15:0] = 16'o177777; devLOBYTE[0] = 1'b0; devHIBYTE[0] = 1'b1;
        tick();
        devWR[0] = 1'b0;
        tick(); tick();
        chk("wr_valid", 64'(trcVALID), 64'd1);
        chk("wr_data",  64'(trcDATA[DATA_MSB:DATA_LSB]), 64'o000377);
        chk("wr_type",  64'(trcDATA[TYPE_BIT]), 64'd1);
        chk("wr_lo",    64'(trcDATA[LO_BIT]),   64'd1);
        chk("wr_hi",    64'(trcDATA[HI_BIT]),   64'd0);
        chk("wr_reg",   64'(trcDATA[REG_MSB:REG_LSB]), 64'd5);
        drain(1);

        // Two back-to-back bursts on all devices from a fresh pointer
        rst_n = 1'b0; tick(); rst_n = 1'b1; tick();
        devRD = 4'hF; tick();
        devRD = 4'h0; tick();
        tick(); tick(); tick();
        devRD = 4'hF; tick();
        devRD = 4'h0;
        repeat (6) tick();
        chk("burst_cnt", 64'(fifoCNT), 64'd8);
        trcREADY = 1'b1;
        for (int j = 0; j < 8; j++) begin
            chk("burst_src", 64'(trcDATA[SRC_MSB:SRC_LSB]), 64'(j % 4));
            tick();
        end
        trcREADY = 1'b0;

        // Overflow: fill, hold one pending, drop the next
        for (int j = 0; j < DEPTH; j++) rd_pulse(0);
        tick(); tick();
        chk("ov_full", 64'(fifoCNT), 64'd16);
        rd_pulse(2);
        chk("ov_pend_ovfl", 64'(ovfl), 64'd0);
        rd_pulse(2);
        chk("ov_drop_ovfl", 64'(ovfl), 64'b0100);
        chk("ov_drop_cnt",  64'(fifoCNT), 64'd16);
        trcREADY = 1'b1; tick(); trcREADY = 1'b0;
        chk("ov_pop_cnt", 64'(fifoCNT), 64'd15);
        tick();
        chk("ov_refill_cnt", 64'(fifoCNT), 64'd16);
        ovflCLR = 1'b1; tick(); ovflCLR = 1'b0;
        chk("ov_clr", 64'(ovfl), 64'd0);
        drain(20);

        // Capture disabled: read ignored, write start still latched
        trcEN = 1'b0;
        rd_pulse(3);
        tick(); tick();
        chk("en_off_valid", 64'(trcVALID), 64'd0);
        devDATA[31:16] = 16'hBEEF; devHIBYTE[1] = 1'b1; devLOBYTE[1] = 1'b1; regSEL[5:3] = 3'd7;
        devWR[1] = 1'b1; tick();
        devDATA[31:16] = 16'h0000; trcEN = 1'b1; tick();
        devWR[1] = 1'b0; tick(); tick();
        chk("en_wr_valid", 64'(trcVALID), 64'd1);
        chk("en_wr_data",  64'(trcDATA[DATA_MSB:DATA_LSB]), 64'hBEEF);
        chk("en_wr_reg",   64'(trcDATA[REG_MSB:REG_LSB]),   64'd7);
        drain(2);

        // Stamp wrap
        devRD = 4'b0011;
        ld_val = 32'hFFFF_FFFE;
        ld_seq++;
        force dut.stamp = 32'hFFFF_FFFE;
        #1 release dut.stamp;
        tick();
        devRD[0] = 1'b0; tick();
        devRD[1] = 1'b0; tick();
        tick(); tick();
        chk("wrap_stamp0", 64'(trcDATA[STAMP_MSB:STAMP_LSB]), 64'hFFFF_FFFF);
        chk("wrap_src0",   64'(trcDATA[SRC_MSB:SRC_LSB]),     64'd0);
        drain(1);
        chk("wrap_stamp1", 64'(trcDATA[STAMP_MSB:STAMP_LSB]), 64'h0000_0000);
        chk("wrap_src1",   64'(trcDATA[SRC_MSB:SRC_LSB]),     64'd1);
        drain(1);

        // Asynchronous reset with records queued
        for (int j = 0; j < 5; j++) rd_pulse(0);
        tick(); tick();
        chk("mr_cnt_before", 64'(fifoCNT), 64'd5);
        rst_n = 1'b0;
        #1;
        chk("mr_valid", 64'(trcVALID), 64'd0);
        chk("mr_cnt",   64'(fifoCNT),  64'd0);
        chk("mr_ovfl",  64'(ovfl),     64'd0);
        chk("mr_data",  64'(trcDATA),  64'd0);
        tick(); tick();
        rst_n = 1'b1;
        repeat (8) tick();
        chk("mr_after_valid", 64'(trcVALID), 64'd0);
        chk("mr_after_cnt",   64'(fifoCNT),  64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
